load_store_unit: RTL
====================

# load_store_unit

Byte/halfword/word load-store sequencer that sits directly upstream of the word-addressed unified memory in the multi-cycle CPU. It accepts one RISC-V load or store request at a time and drives the memory's single port (addr, din, mem_read, mem_write). Sub-word stores are done as read-modify-write. Load results are returned aligned and sign- or zero-extended.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present; sampled only when req_ready=1.
- req_ready  out  1  high only in IDLE and when reset=0.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle pulse when the request completes.
- resp_rdata  out  32  load result; 0 for stores and errors; valid only while resp_valid=1.
- resp_error  out  1  high with resp_valid when the request was misaligned or had an illegal funct3.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00} in RD/WR; 0 otherwise.
- mem_din  out  32  write word in WR; 0 otherwise.
- mem_read  out  1  high in RD only.
- mem_write  out  1  high in WR only, gated by !reset.
- mem_dout  in  32  asynchronous read data from memory (0 when mem_read=0).

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: on req_valid, register write, funct3, addr and wdata, then decode.
  - Error: illegal funct3, LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0 → DONE with error. No memory access occurs.
  - SW → WR.
  - Any load, SB, SH → RD.
- RD: mem_read=1. At the clock edge, capture mem_dout into a word register.
  - Load → DONE.
  - SB/SH → WR.
- WR: mem_write=1.
  - SW: mem_din = wdata.
  - SB: mem_din = captured word with byte lane addr[1:0] (bits 8k+7:8k) replaced by wdata[7:0].
  - SH: mem_din = captured word with halfword lane addr[1] replaced by wdata[15:0].
  - Next state → DONE.
- DONE: resp_valid=1, with resp_error as decoded. Next state → IDLE.
- Load extraction is little-endian. For lane k: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- resp_rdata is computed from the registered word and the request in DONE.
- Reset: state → IDLE; all registers → 0.
  - Output reset values: req_ready=0 during reset, 1 after; resp_valid=0, resp_rdata=0, resp_error=0, mem_addr=0, mem_din=0, mem_read=0, mem_write=0.
  - Reset asserted in RD/WR/DONE aborts the request: no write is issued and no response is produced.
- req_valid asserted outside IDLE is ignored; the requester must hold it until accepted.

## Timing
- Cycle 0 is the IDLE accept edge.
- LW/LB/LH/LBU/LHU: RD in cycle 1, resp_valid in cycle 2.
- SW: WR in cycle 1, resp_valid in cycle 2. The memory is updated at the end of cycle 1.
- SB/SH: RD in cycle 1, WR in cycle 2, resp_valid in cycle 3.
- Error: resp_valid in cycle 1, with no mem_read or mem_write.
- A new request can be accepted in the cycle after DONE. Maximum throughput is one request per 3 cycles (4 for SB/SH).
- The RD→WR merge uses the registered word, not mem_dout, because mem_dout is 0 in WR.

## Test plan
- Word 0x100 preset to 0x11223344; LW addr 0x100 → resp_rdata=0x11223344 at cycle 2; mem_read high only in cycle 1.
- Word 0x100 = 0x80FF7F01:
  - LB 0x101 → 0x0000007F.
  - LB 0x102 → 0xFFFFFFFF.
  - LBU 0x103 → 0x00000080.
  - LH 0x102 → 0xFFFF80FF.
  - LHU 0x102 → 0x000080FF.
- Word 0x200 = 0xAABBCCDD; SB addr 0x201 wdata 0x12345678 → memory word becomes 0xAABB78DD; mem_write only in cycle 2; resp_valid at cycle 3 with rdata 0.
- SH addr 0x202 wdata 0x0000BEEF over 0xAABBCCDD → 0xBEEFCCDD.
- SW addr 0x300 wdata 0xCAFEF00D → memory word written; no mem_read cycle.
- Error cases: LW 0x102, SH 0x203, and load funct3 011 → each gives resp_error=1, resp_rdata=0, at cycle 1, with no memory strobes.
- Reset asserted during the SB RD cycle → no mem_write afterwards; the target word is unchanged; req_ready=1 after reset deasserts.

Source files
------------

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store sequencer in front of a single-port, word-addressed memory.
// Sub-word stores are read-modify-write; loads return aligned, sign- or zero-extended data.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state, state_next;
    logic        write_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] word_r;
    logic        error_r;
    logic        req_bad;

    function automatic logic req_illegal(input logic write, input logic [2:0] f3,
                                         input logic [1:0] a);
        logic bad;
        bad = 1'b1;
        case (f3)
            3'b000:         bad = 1'b0;
            3'b001:         bad = a[0];
            3'b010:         bad = (a != 2'b00);
            3'b100:         bad = write;
            3'b101:         bad = write | a[0];
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] a);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = 32'(b);
            3'b001:  res = 32'(h);
            3'b100:  res = {24'h0, b};
            3'b101:  res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] res;
        res = word;
        case (f3)
            3'b000:  res[{a, 3'b000} +: 8] = wdata[7:0];
            3'b001:  res[{a[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    assign req_bad = req_illegal(req_write, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            write_r  <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= 32'h0;
            wdata_r  <= 32'h0;
            word_r   <= 32'h0;
            error_r  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                write_r  <= req_write;
                funct3_r <= req_funct3;
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
                error_r  <= req_bad;
            end
            // Keep the read word: mem_dout drops to 0 once mem_read falls in WR.
            if (state == RD)
                word_r <= mem_dout;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad)
                        state_next = DONE;
                    else if (req_write && req_funct3 == 3'b010)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = write_r ? WR : DONE;
            WR:      state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_error = 1'b0;
        mem_addr   = 32'h0;
        mem_din    = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: req_ready = 1'b1;
                RD: begin
                    mem_read = 1'b1;
                    mem_addr = {addr_r[31:2], 2'b00};
                end
                WR: begin
                    mem_write = 1'b1;
                    mem_addr  = {addr_r[31:2], 2'b00};
                    mem_din   = store_merge(word_r, wdata_r, funct3_r, addr_r[1:0]);
                end
                default: begin
                    resp_valid = 1'b1;
                    resp_error = error_r;
                    if (!error_r && !write_r)
                        resp_rdata = load_extract(word_r, funct3_r, addr_r[1:0]);
                end
            endcase
        end
    end

endmodule
